// File: rtl/micro_alpha_veryl_shift_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : micro_alpha_veryl_shift_sequencer                               |
// | Brief    : Iterates the single-bit shifter COUNT times behind two          |
// |            valid/ready handshakes. Optional MICRO_ALPHA_SHIFT_SEQ_ROTATE_EN |
// |            adds a rotate input for the logical shifts.                     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

package micro_alpha_veryl_pkg;
    typedef enum logic [2:0] {
        NOP                  = 3'd0,
        LEFT_LOGICALLY       = 3'd1,
        LEFT_ARITHMETICALLY  = 3'd2,
        RIGHT_LOGICALLY      = 3'd3,
        RIGHT_ARITHMETICALLY = 3'd4,
        EXTENSION            = 3'd5,
        SWAP                 = 3'd6
    } shifter_operation_t;
endpackage

module micro_alpha_veryl_shifter
    import micro_alpha_veryl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               [WIDTH-1:0] in,
    input  shifter_operation_t             operation,
    input  logic                           cin,
    output logic               [WIDTH-1:0] out,
    output logic                           cout
);
    always_comb begin
        out  = in;
        cout = 1'b0;
        case (operation)
            LEFT_LOGICALLY, LEFT_ARITHMETICALLY: begin
                out  = {in[WIDTH-2:0], cin};
                cout = in[WIDTH-1];
            end
            RIGHT_LOGICALLY: begin
                out  = {cin, in[WIDTH-1:1]};
                cout = in[0];
            end
            RIGHT_ARITHMETICALLY: begin
                out  = {in[WIDTH-1], in[WIDTH-1:1]};
                cout = in[0];
            end
            EXTENSION: out = {{(WIDTH-8){in[7]}}, in[7:0]};
            SWAP:      out = {in[WIDTH/2-1:0], in[WIDTH-1:WIDTH/2]};
            default:   out = in;
        endcase
    end
endmodule

module micro_alpha_veryl_shift_sequencer
    import micro_alpha_veryl_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_valid,
    output logic                               start_ready,
    input  shifter_operation_t                 operation,
    input  logic               [WIDTH-1:0]     data,
    input  logic               [CNT_WIDTH-1:0] count,
    input  logic                               cin,
`ifdef MICRO_ALPHA_SHIFT_SEQ_ROTATE_EN
    input  logic                               rotate,
`endif
    output logic                               result_valid,
    input  logic                               result_ready,
    output logic               [WIDTH-1:0]     result,
    output logic                               cout,
    output logic                               busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_cnt_zero = '0;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    shifter_operation_t       r_op;
    logic [WIDTH-1:0]         r_acc;
    logic                     r_cout;
    logic                     r_cin;
    logic [CNT_WIDTH-1:0]     r_remaining;
    logic [CNT_WIDTH-1:0]     w_start_count;
    logic                     w_start_is_shift;
    logic                     w_step_cin;
    logic [WIDTH-1:0]         w_sh_out;
    logic                     w_sh_cout;

    always_comb begin
        w_start_is_shift = 1'b0;
        case (operation)
            LEFT_LOGICALLY, LEFT_ARITHMETICALLY,
            RIGHT_LOGICALLY, RIGHT_ARITHMETICALLY: w_start_is_shift = 1'b1;
            default:                                w_start_is_shift = 1'b0;
        endcase
    end

    // A zero count bypasses the shifter entirely, even for non-shift operations.
    always_comb begin
        w_start_count = c_cnt_zero;
        if (count != c_cnt_zero) begin
            w_start_count = w_start_is_shift ? count : c_cnt_one;
        end
    end

`ifdef MICRO_ALPHA_SHIFT_SEQ_ROTATE_EN
    logic r_rotate;

    // Rotating feeds the bit leaving the word back into the vacated end.
    always_comb begin
        w_step_cin = r_cin;
        if (r_rotate && (r_op == LEFT_LOGICALLY)) begin
            w_step_cin = r_acc[WIDTH-1];
        end else if (r_rotate && (r_op == RIGHT_LOGICALLY)) begin
            w_step_cin = r_acc[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rotate <= 1'b0;
        end else if ((r_state == S_IDLE) && start_valid) begin
            r_rotate <= rotate;
        end
    end
`else
    always_comb begin
        w_step_cin = r_cin;
    end
`endif

    micro_alpha_veryl_shifter #(
        .WIDTH     (WIDTH)
    ) u_shifter (
        .in        (r_acc),
        .operation (r_op),
        .cin       (w_step_cin),
        .out       (w_sh_out),
        .cout      (w_sh_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        start_ready  = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_valid) begin
                    w_state_nxt = (w_start_count == c_cnt_zero) ? S_DONE : S_STEP;
                end
            end
            S_STEP: begin
                if (r_remaining == c_cnt_one) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op        <= NOP;
            r_acc       <= '0;
            r_cout      <= 1'b0;
            r_cin       <= 1'b0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_op        <= operation;
                        r_acc       <= data;
                        r_cin       <= cin;
                        r_cout      <= 1'b0;
                        r_remaining <= w_start_count;
                    end
                end
                S_STEP: begin
                    r_acc       <= w_sh_out;
                    r_cout      <= w_sh_cout;
                    r_remaining <= r_remaining - c_cnt_one;
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_acc;
    assign cout   = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_micro_alpha_veryl_shift_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_micro_alpha_veryl_shift_sequencer                            |
// | Brief    : Directed self-checking bench for the multi-cycle shift sequencer.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_micro_alpha_veryl_shift_sequencer;
    import micro_alpha_veryl_pkg::*;

    logic               clk;
    logic               rst;
    logic               start_valid;
    logic               start_ready;
    shifter_operation_t operation;
    logic [15:0]        data;
    logic [3:0]         count;
    logic               cin;
    logic               result_valid;
    logic               result_ready;
    logic [15:0]        result;
    logic               cout;
    logic               busy;
`ifdef MICRO_ALPHA_SHIFT_SEQ_ROTATE_EN
    logic               rotate;
`endif

    int n_cmp;
    int n_err;

    micro_alpha_veryl_shift_sequencer #(
        .WIDTH        (16),
        .CNT_WIDTH    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .operation    (operation),
        .data         (data),
        .count        (count),
        .cin          (cin),
`ifdef MICRO_ALPHA_SHIFT_SEQ_ROTATE_EN
        .rotate       (rotate),
`endif
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .cout         (cout),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request, waits for the accept edge and returns the observed latency.
    task automatic issue(input shifter_operation_t op, input logic [15:0] d, input logic [3:0] n,
                         input logic ci, input logic rot, output int lat);
        tick();
        start_valid = 1'b1;
        operation   = op;
        data        = d;
        count       = n;
        cin         = ci;
`ifdef MICRO_ALPHA_SHIFT_SEQ_ROTATE_EN
        rotate      = rot;
`else
        if (rot) $display("note: rotate requested without rotate build");
`endif
        chk("start_ready_idle", {31'b0, start_ready}, 32'd1);
        tick();
        start_valid = 1'b0;
        lat = 1;
        while (!result_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!result_valid) chk("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic consume();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("start_ready_after", {31'b0, start_ready}, 32'd1);
        chk("valid_after", {31'b0, result_valid}, 32'd0);
    endtask

    task automatic run(input string tag, input shifter_operation_t op, input logic [15:0] d,
                       input logic [3:0] n, input logic ci, input logic rot,
                       input logic [15:0] exp_res, input logic exp_cout, input int exp_lat);
        int lat;
        issue(op, d, n, ci, rot, lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, {16'b0, result}, {16'b0, exp_res});
        chk({tag, "_cout"}, {31'b0, cout}, {31'b0, exp_cout});
        consume();
    endtask

    initial begin
        int  lat;
        logic seen;
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b0;
        start_valid  = 1'b0;
        result_ready = 1'b0;
        operation    = NOP;
        data         = 16'h0;
        count        = 4'd0;
        cin          = 1'b0;
`ifdef MICRO_ALPHA_SHIFT_SEQ_ROTATE_EN
        rotate       = 1'b0;
`endif
        repeat (3) tick();
        rst = 1'b1;
        chk("rst_valid", {31'b0, result_valid}, 32'd0);
        chk("rst_result", {16'b0, result}, 32'd0);
        chk("rst_cout", {31'b0, cout}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ready", {31'b0, start_ready}, 32'd1);

        run("sll4",   LEFT_LOGICALLY,       16'hA5A5, 4'd4,  1'b0, 1'b0, 16'h5A50, 1'b0, 5);
        run("sra15",  RIGHT_ARITHMETICALLY, 16'h8000, 4'd15, 1'b1, 1'b0, 16'hFFFF, 1'b0, 16);
        run("sll1",   LEFT_LOGICALLY,       16'h8000, 4'd1,  1'b1, 1'b0, 16'h0001, 1'b1, 2);
        run("sll0",   LEFT_LOGICALLY,       16'h1234, 4'd0,  1'b0, 1'b0, 16'h1234, 1'b0, 1);
        run("swap7",  SWAP,                 16'h0123, 4'd7,  1'b0, 1'b0, 16'h2301, 1'b0, 2);
        run("ext3",   EXTENSION,            16'h0080, 4'd3,  1'b0, 1'b0, 16'hFF80, 1'b0, 2);
        run("nop0",   NOP,                  16'hBEEF, 4'd0,  1'b0, 1'b0, 16'hBEEF, 1'b0, 1);
        run("sla2",   LEFT_ARITHMETICALLY,  16'h4001, 4'd2,  1'b1, 1'b0, 16'h0007, 1'b1, 3);

        // Consumer stalls; output must hold and a new request must be ignored.
        issue(RIGHT_LOGICALLY, 16'hA5A5, 4'd1, 1'b1, 1'b0, lat);
        chk("srl1_lat", lat, 32'd2);
        for (int i = 0; i < 3; i++) begin
            start_valid = (i == 1);
            data        = 16'h0F0F;
            count       = 4'd3;
            chk("hold_res", {16'b0, result}, 32'h0000D2D2);
            chk("hold_cout", {31'b0, cout}, 32'd1);
            chk("hold_sready", {31'b0, start_ready}, 32'd0);
            chk("hold_valid", {31'b0, result_valid}, 32'd1);
            tick();
        end
        start_valid = 1'b0;
        chk("hold_res_end", {16'b0, result}, 32'h0000D2D2);
        consume();
        chk("idle_busy", {31'b0, busy}, 32'd0);

        // Reset mid-operation aborts without producing a result.
        tick();
        start_valid = 1'b1;
        operation   = LEFT_LOGICALLY;
        data        = 16'h00FF;
        count       = 4'd10;
        cin         = 1'b0;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_valid", {31'b0, result_valid}, 32'd0);
        chk("abort_result", {16'b0, result}, 32'd0);
        chk("abort_sready", {31'b0, start_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (result_valid) seen = 1'b1;
            tick();
        end
        chk("abort_no_result", {31'b0, seen}, 32'd0);

`ifdef MICRO_ALPHA_SHIFT_SEQ_ROTATE_EN
        run("rol1", LEFT_LOGICALLY,  16'h8001, 4'd1, 1'b0, 1'b1, 16'h0003, 1'b1, 2);
        run("ror4", RIGHT_LOGICALLY, 16'h0001, 4'd4, 1'b0, 1'b1, 16'h1000, 1'b0, 5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
